// File: rtl/tamagotchi_pkg.sv
// Shared definitions for the tamagotchi action-input path: action indices,
// the grant FSM state encoding, and a priority helper used by the arbiter.
package tamagotchi_pkg;

    // Button / action indices as they appear on btn_in and action.
    localparam int ACT_FEED  = 0;
    localparam int ACT_PLAY  = 1;
    localparam int ACT_CLEAN = 2;
    localparam int ACT_SLEEP = 3;
    localparam int N_ACTIONS = 4;

    // Grant FSM states. Encoding 2'd3 is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EMIT     = 2'd1,
        COOLDOWN = 2'd2
    } fsm_state_t;

    // Isolate the lowest set bit (lowest index wins); zero in, zero out.
    function automatic logic [N_ACTIONS-1:0] lowest_onehot(input logic [N_ACTIONS-1:0] v);
        return v & (~v + {{(N_ACTIONS-1){1'b0}}, 1'b1});
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-flop synchroniser, debounce counter holding the
// accepted (stable) level, and a one-cycle pulse on each accepted 0->1 edge.
module btn_debounce #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic stable,
    output logic rise
);

    logic        sync1;
    logic        sync2;
    logic        stable_q;
    logic [15:0] cnt;

    // Synchronise the raw pin, then accept sync2 as the new stable level only
    // after it has disagreed with the current level for DEBOUNCE_CYCLES in a
    // row; any agreeing sample restarts the count, so short glitches vanish.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            stable   <= 1'b0;
            stable_q <= 1'b0;
            cnt      <= '0;
        end else begin
            sync1    <= btn;
            sync2    <= sync1;
            stable_q <= stable;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == DEBOUNCE_CYCLES - 16'd1) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 16'd1;
            end
        end
    end

    // High for exactly the cycle after stable goes 0->1; release gives nothing.
    assign rise = stable & ~stable_q;

endmodule

// File: rtl/action_input.sv
// Turns the four raw player buttons into one-hot, single-cycle action commands.
// Each button is conditioned by btn_debounce; a grant FSM then serialises the
// accepted presses and holds off new ones for a cooldown period, so one press
// moves one stat by exactly one step.
//
// Build option: define ACTION_AUTO_REPEAT_EN to let a held button re-issue its
// action every COOLDOWN_CYCLES+2 cycles. Without it only fresh presses count.
//
// Output handshake: action_valid is a one-cycle push with no back-pressure.
// action is meaningful only in the cycle action_valid=1 and the consumer must
// take it in that cycle; outside that cycle action holds its last value.
module action_input
    import tamagotchi_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50_000,
    parameter logic [23:0] COOLDOWN_CYCLES = 24'd10_000_000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_ACTIONS-1:0] btn_in,
    input  logic                 enable,
    output logic [N_ACTIONS-1:0] action,
    output logic                 action_valid,
    output logic                 busy,
    output logic [N_ACTIONS-1:0] btn_state
);

    logic [N_ACTIONS-1:0] stable_vec;
    logic [N_ACTIONS-1:0] rise_vec;
    logic [N_ACTIONS-1:0] pending;
    logic [N_ACTIONS-1:0] candidates;
    logic [23:0]          cool_cnt;

    // Current grant state; kept as a named signal so checkers can bind to it.
    fsm_state_t           state;

    // One conditioning channel per button.
    for (genvar i = 0; i < N_ACTIONS; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk   (clk),
            .reset (reset),
            .btn   (btn_in[i]),
            .stable(stable_vec[i]),
            .rise  (rise_vec[i])
        );
    end

    assign btn_state = stable_vec;

    // Requests the arbiter may grant from IDLE.
`ifdef ACTION_AUTO_REPEAT_EN
    // A button still held down keeps requesting even without a new edge.
    assign candidates = pending | stable_vec;
`else
    // Only latched press edges request an action.
    assign candidates = pending;
`endif

    // Grant FSM: pick the lowest-index request, pulse it for one cycle, then
    // sit out the cooldown. Press edges are latched only while IDLE; anything
    // that arrives during EMIT/COOLDOWN is dropped on purpose.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            pending      <= '0;
            action       <= '0;
            action_valid <= 1'b0;
            busy         <= 1'b0;
            cool_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable && (candidates != '0)) begin
                        // Losers of a simultaneous press are discarded here.
                        action       <= lowest_onehot(candidates);
                        pending      <= '0;
                        action_valid <= 1'b1;
                        busy         <= 1'b1;
                        state        <= EMIT;
                    end else begin
                        // Disabled or nothing requested: keep accumulating.
                        pending <= pending | rise_vec;
                    end
                end
                EMIT: begin
                    action_valid <= 1'b0;
                    cool_cnt     <= '0;
                    state        <= COOLDOWN;
                end
                COOLDOWN: begin
                    if (cool_cnt == COOLDOWN_CYCLES - 24'd1) begin
                        cool_cnt <= '0;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        cool_cnt <= cool_cnt + 24'd1;
                    end
                end
                default: begin
                    pending      <= '0;
                    action_valid <= 1'b0;
                    busy         <= 1'b0;
                    cool_cnt     <= '0;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_action_input.sv
// Self-checking bench for action_input with short debounce/cooldown settings.
// A timestamp-based reference model predicts, per clock edge, the debounced
// levels, the grant pulses, the held action code and busy.
module tb_action_input;

    localparam int D = 4;
    localparam int C = 8;

    logic       clk;
    logic       reset;
    logic [3:0] btn_in;
    logic       enable;
    logic [3:0] action;
    logic       action_valid;
    logic       busy;
    logic [3:0] btn_state;

    action_input #(
        .DEBOUNCE_CYCLES(16'(D)),
        .COOLDOWN_CYCLES(24'(C))
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_in      (btn_in),
        .enable      (enable),
        .action      (action),
        .action_valid(action_valid),
        .busy        (busy),
        .btn_state   (btn_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- counters and scoreboard ----------------
    int         n_cmp  = 0;
    int         n_fail = 0;
    int         cyc    = 0;
    logic [3:0] exp_q[$];
    int         pulse_edges[$];

    // ---------------- reference model state ----------------
    logic [3:0] hist[$];      // synchronised samples, oldest first
    logic [3:0] m_stable;
    logic [3:0] m_rise;
    logic [3:0] m_pending;
    logic [3:0] m_action;
    logic       m_valid;
    int         free_at;      // first edge at which the grantor is idle again

    function automatic logic [3:0] first_set(input logic [3:0] v);
        for (int i = 0; i < 4; i++) begin
            if (v[i]) return 4'(1 << i);
        end
        return 4'b0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge with the inputs sampled at that edge.
    task automatic model_edge(input logic [3:0] b, input logic en, input logic rst);
        logic [3:0] cand;
        logic [3:0] new_rise;
        logic       all_diff;
        int         n;
        if (rst) begin
            hist.delete();
            for (int k = 0; k < D + 2; k++) hist.push_back(4'b0000);
            m_stable  = '0;
            m_rise    = '0;
            m_pending = '0;
            m_action  = '0;
            m_valid   = 1'b0;
            free_at   = 0;
            exp_q.delete();
            return;
        end
        // Arbitration uses state from before this edge.
        m_valid = 1'b0;
        if (cyc >= free_at) begin
            cand = m_pending;
`ifdef ACTION_AUTO_REPEAT_EN
            cand = cand | m_stable;
`endif
            if (en && cand != 4'b0000) begin
                m_action  = first_set(cand);
                m_valid   = 1'b1;
                m_pending = '0;
                free_at   = cyc + C + 2;
                exp_q.push_back(m_action);
            end else begin
                m_pending = m_pending | m_rise;
            end
        end
        // A level is accepted once the last D synchronised samples all disagree.
        n = hist.size();
        new_rise = '0;
        for (int i = 0; i < 4; i++) begin
            all_diff = 1'b1;
            for (int k = 0; k < D; k++) begin
                if (hist[n - 2 - k][i] == m_stable[i]) all_diff = 1'b0;
            end
            if (all_diff) begin
                m_stable[i] = ~m_stable[i];
                if (m_stable[i]) new_rise[i] = 1'b1;
            end
        end
        m_rise = new_rise;
        hist.push_back(b);
        if (hist.size() > D + 4) void'(hist.pop_front());
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic [3:0] b, input logic en, input logic rst);
        logic [3:0] got;
        @(negedge clk);
        btn_in = b;
        enable = en;
        reset  = rst;
        @(posedge clk);
        cyc++;
        model_edge(b, en, rst);
        #1;
        check("action_valid", action_valid, m_valid);
        check("busy", busy, (cyc + 1 < free_at));
        check("btn_state", btn_state, m_stable);
        check("action_hold", action, m_action);
        if (action_valid === 1'b1) begin
            pulse_edges.push_back(cyc);
            if (exp_q.size() > 0) begin
                got = exp_q.pop_front();
                check("sb_action", action, got);
            end else begin
                check("sb_spurious", action_valid, 1'b0);
            end
        end
    endtask

    task automatic hold(input logic [3:0] b, input logic en, input int cycles);
        for (int i = 0; i < cycles; i++) step(b, en, 1'b0);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int start;
        btn_in = '0;
        enable = 1'b1;
        reset  = 1'b1;

        // Reset and quiet idle.
        step(4'b0000, 1'b1, 1'b1);
        step(4'b0000, 1'b1, 1'b1);
        check("reset_action", action, 4'b0000);
        check("reset_valid", action_valid, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_btn_state", btn_state, 4'b0000);
        pulse_edges.delete();
        hold(4'b0000, 1'b1, 50);
        check("idle_no_pulse", pulse_edges.size(), 0);

        // Clean feed press held.
        pulse_edges.delete();
        start = cyc + 1;
        hold(4'b0001, 1'b1, 30);
`ifdef ACTION_AUTO_REPEAT_EN
        check("repeat_count_min", (pulse_edges.size() >= 2), 1);
        if (pulse_edges.size() >= 2)
            check("repeat_period", pulse_edges[1] - pulse_edges[0], C + 2);
`else
        check("feed_pulse_count", pulse_edges.size(), 1);
        if (pulse_edges.size() >= 1)
            check("feed_latency", pulse_edges[0] - start + 1, D + 4);
`endif
        hold(4'b0000, 1'b1, 20);

        // Bouncing play button, then held.
        pulse_edges.delete();
        step(4'b0010, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        step(4'b0010, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        check("bounce_not_stable", btn_state[1], 1'b0);
        hold(4'b0010, 1'b1, 30);
        hold(4'b0000, 1'b1, 20);
`ifndef ACTION_AUTO_REPEAT_EN
        check("bounce_pulse_count", pulse_edges.size(), 1);
`endif

        // Simultaneous clean + sleep.
        pulse_edges.delete();
        hold(4'b1100, 1'b1, 30);
        hold(4'b0000, 1'b1, 20);
`ifndef ACTION_AUTO_REPEAT_EN
        check("simul_pulse_count", pulse_edges.size(), 1);
`endif

        // Press held off by enable=0, then released by enable=1.
        pulse_edges.delete();
        hold(4'b0010, 1'b0, 30);
        check("disabled_no_pulse", pulse_edges.size(), 0);
        hold(4'b0010, 1'b1, 2);
        check("enable_grant", pulse_edges.size(), 1);
        hold(4'b0000, 1'b1, 20);

        // Press arriving during cooldown is dropped.
        pulse_edges.delete();
        for (int i = 0; i < 20 && pulse_edges.size() == 0; i++) step(4'b0001, 1'b1, 1'b0);
        check("cd_first_grant", pulse_edges.size(), 1);
        hold(4'b0100, 1'b1, 12);
        hold(4'b0000, 1'b1, 20);
        check("cd_press_dropped", pulse_edges.size(), 1);

        // Reset three cycles into cooldown, then a normal press.
        pulse_edges.delete();
        for (int i = 0; i < 20 && pulse_edges.size() == 0; i++) step(4'b0001, 1'b1, 1'b0);
        check("mid_cd_grant", pulse_edges.size(), 1);
        hold(4'b0001, 1'b1, 4);
        step(4'b0000, 1'b1, 1'b1);
        check("mid_cd_busy", busy, 1'b0);
        check("mid_cd_action", action, 4'b0000);
        hold(4'b0000, 1'b1, 10);
        pulse_edges.delete();
        hold(4'b1000, 1'b1, 20);
        check("post_reset_grant", (pulse_edges.size() >= 1), 1);
        hold(4'b0000, 1'b1, 20);

        // Randomised segments with occasional disable and reset.
        for (int s = 0; s < 80; s++) begin
            logic [3:0] b;
            logic       en;
            int         len;
            b   = 4'($urandom_range(0, 15));
            en  = ($urandom_range(0, 3) != 0);
            len = $urandom_range(1, 14);
            if ($urandom_range(0, 24) == 0) step(4'b0000, 1'b1, 1'b1);
            hold(b, en, len);
        end
        hold(4'b0000, 1'b1, 30);
        check("exp_q_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
